div_seq: RTL and testbench

- Multi-cycle sequencer for the RV32M divide/remainder ops (`ALU_DIV, `ALU_DIVU, `ALU_REM, `ALU_REMU from define.vh) emitted by the decoder.
- Sits beside the single-cycle ALU in the execute stage. Accepts operands on a start pulse and runs a radix-2 restoring divider, one quotient bit per clock.
- Holds the pipeline with a stall signal until the result is ready. Supports flush on branch or jump redirect.

---
 rtl/div_seq.sv | 191 +++++++++++++++++++
 tb/tb_div_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// rtl/div_seq.sv - radix-2 restoring divide/remainder sequencer for RV32M DIV/DIVU/REM/REMU
// Optional feature macro: DIV_FASTPATH_EN (skip the iteration loop for trivial operands)
module div_seq #(
    parameter int         XLEN     = 32,
    parameter logic [5:0] ALU_DIV  = 6'd20,
    parameter logic [5:0] ALU_DIVU = 6'd21,
    parameter logic [5:0] ALU_REM  = 6'd22,
    parameter logic [5:0] ALU_REMU = 6'd23
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [5:0]      alucode,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    localparam int              CW      = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_RUN  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Latched operation and iteration datapath
    logic [5:0]      code_q;
    logic [XLEN-1:0] op1_q, op2_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] rem_q, quo_q;
    logic [CW-1:0]   cnt_q;
    logic            qneg_q, rneg_q;
    logic            dz_q, ovf_q;

    // Registered outputs
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            in_is_div, accept;
    logic            op_signed, op_is_rem;
    logic            op1_neg, op2_neg;
    logic [XLEN-1:0] abs1, abs2;
    logic            dz_w, ovf_w, go_fast;
    logic [XLEN:0]   rem_sh;
    logic            trial_ge;
    logic [XLEN-1:0] trial_rem;
    logic [XLEN-1:0] quo_fix, rem_fix, fix_val;

    assign in_is_div = (alucode == ALU_DIV) || (alucode == ALU_DIVU) ||
                       (alucode == ALU_REM) || (alucode == ALU_REMU);
    assign accept    = (state_q == S_IDLE) && start && in_is_div && !flush;

    assign op_signed = (code_q == ALU_DIV) || (code_q == ALU_REM);
    assign op_is_rem = (code_q == ALU_REM) || (code_q == ALU_REMU);

    // Magnitudes; INT_MIN maps to itself, which is its correct unsigned magnitude
    assign op1_neg = op_signed && op1_q[XLEN-1];
    assign op2_neg = op_signed && op2_q[XLEN-1];
    assign abs1    = op1_neg ? (-op1_q) : op1_q;
    assign abs2    = op2_neg ? (-op2_q) : op2_q;

    assign dz_w  = (op2_q == '0);
    assign ovf_w = op_signed && (op1_q == INT_MIN) && (op2_q == '1);

`ifdef DIV_FASTPATH_EN
    assign go_fast = dz_w || ovf_w || (abs1 < abs2);
`else
    assign go_fast = 1'b0;
`endif

    // One restoring step: the shifted partial remainder needs XLEN+1 bits,
    // but after a successful subtract it always fits back in XLEN bits.
    assign rem_sh    = {rem_q, quo_q[XLEN-1]};
    assign trial_ge  = (rem_sh >= {1'b0, dvs_q});
    assign trial_rem = rem_sh[XLEN-1:0] - dvs_q;

    assign quo_fix = qneg_q ? (-quo_q) : quo_q;
    assign rem_fix = rneg_q ? (-rem_q) : rem_q;

    // Final value selection; RISC-V special cases override the raw datapath
    always_comb begin
        fix_val = op_is_rem ? rem_fix : quo_fix;
        if (dz_q) begin
            fix_val = op_is_rem ? op1_q : '1;
        end else if (ovf_q) begin
            fix_val = op_is_rem ? '0 : INT_MIN;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; flush wins over every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_PREP;
            S_PREP: state_d = go_fast ? S_FIX : S_RUN;
            S_RUN:  if (cnt_q == CW'(1)) state_d = S_FIX;
            S_FIX:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // FSM outputs: busy follows the next state, valid only from an unflushed FIX
    always_comb begin
        busy_d   = (state_d != S_IDLE);
        valid_d  = (state_q == S_FIX) && !flush;
        result_d = valid_d ? fix_val : result_q;
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    // Operand latch, pre-processing and iteration datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= '0;
            op1_q  <= '0;
            op2_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        code_q <= alucode;
                        op1_q  <= op1;
                        op2_q  <= op2;
                    end
                end
                S_PREP: begin
                    qneg_q <= op1_neg ^ op2_neg;
                    rneg_q <= op1_neg;
                    dz_q   <= dz_w;
                    ovf_q  <= ovf_w;
                    dvs_q  <= abs2;
                    cnt_q  <= CW'(XLEN);
                    rem_q  <= go_fast ? abs1 : '0;
                    quo_q  <= go_fast ? '0 : abs1;
                end
                S_RUN: begin
                    rem_q <= trial_ge ? trial_rem : rem_sh[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], trial_ge};
                    cnt_q <= cnt_q - CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign valid  = valid_q;
    assign result = result_q;
    assign stall  = busy_q || (start && in_is_div && (state_q == S_IDLE));

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - directed self-checking bench for div_seq
module tb_div_seq;

    localparam logic [5:0] C_ADD  = 6'd0;
    localparam logic [5:0] C_DIV  = 6'd20;
    localparam logic [5:0] C_DIVU = 6'd21;
    localparam logic [5:0] C_REM  = 6'd22;
    localparam logic [5:0] C_REMU = 6'd23;
    localparam int         FULL_LAT = 34;
`ifdef DIV_FASTPATH_EN
    localparam int         SPEC_LAT = 2;
`else
    localparam int         SPEC_LAT = 34;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  alucode;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        valid;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    div_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .alucode (alucode),
        .op1     (op1),
        .op2     (op2),
        .flush   (flush),
        .busy    (busy),
        .stall   (stall),
        .valid   (valid),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one op from a negedge; return edges from start edge to valid,
    // the result, and whether busy/stall/valid were correct throughout.
    task automatic do_op(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output bit hs_ok);
        int k;
        hs_ok   = 1'b1;
        lat     = -1;
        res     = 32'hDEAD_BEEF;
        start   = 1'b1;
        alucode = code;
        op1     = a;
        op2     = b;
        #1;
        if (stall !== 1'b1) hs_ok = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (k <= 200) begin
            if (valid === 1'b1) begin
                lat = k;
                res = result;
                if (busy !== 1'b0 || stall !== 1'b0) hs_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1 || stall !== 1'b1) hs_ok = 1'b0;
            @(posedge clk);
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; alucode = C_ADD; op1 = '0; op2 = '0;
        #3;
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got=%b want=0", valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h want=0", result); end
        checks++; if (stall !== 1'b0)  begin errors++; $display("FAIL reset_stall got=%b want=0", stall); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned;
        int lat; logic [31:0] res; bit ok;
        do_op(C_DIVU, 32'd100, 32'd7, lat, res, ok);
        checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_res got=%h want=%h", res, 32'd14); end
        checks++; if (lat !== FULL_LAT) begin errors++; $display("FAIL divu_lat got=%0d want=%0d", lat, FULL_LAT); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL divu_handshake got=%b want=1", ok); end
        @(negedge clk);
        do_op(C_REMU, 32'd100, 32'd7, lat, res, ok);
        checks++; if (res !== 32'd2) begin errors++; $display("FAIL remu_res got=%h want=%h", res, 32'd2); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL remu_handshake got=%b want=1", ok); end
        @(negedge clk);
    endtask

    task automatic test_signed;
        int lat; logic [31:0] res; bit ok;
        do_op(C_DIV, 32'hFFFF_FFEC, 32'd6, lat, res, ok);
        checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_res got=%h want=FFFFFFFD", res); end
        @(negedge clk);
        do_op(C_REM, 32'hFFFF_FFEC, 32'd6, lat, res, ok);
        checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL rem_neg_res got=%h want=FFFFFFFE", res); end
        @(negedge clk);
        do_op(C_DIV, 32'd20, 32'hFFFF_FFFA, lat, res, ok);
        checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negdivisor_res got=%h want=FFFFFFFD", res); end
        @(negedge clk);
        do_op(C_REM, 32'd20, 32'hFFFF_FFFA, lat, res, ok);
        checks++; if (res !== 32'd2) begin errors++; $display("FAIL rem_negdivisor_res got=%h want=2", res); end
        @(negedge clk);
    endtask

    task automatic test_special;
        int lat; logic [31:0] res; bit ok;
        do_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, ok);
        checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_res got=%h want=80000000", res); end
        checks++; if (lat !== SPEC_LAT) begin errors++; $display("FAIL div_ovf_lat got=%0d want=%0d", lat, SPEC_LAT); end
        @(negedge clk);
        do_op(C_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, ok);
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL rem_ovf_res got=%h want=0", res); end
        @(negedge clk);
        do_op(C_DIVU, 32'd5, 32'd0, lat, res, ok);
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_dz_res got=%h want=FFFFFFFF", res); end
        checks++; if (lat !== SPEC_LAT) begin errors++; $display("FAIL divu_dz_lat got=%0d want=%0d", lat, SPEC_LAT); end
        @(negedge clk);
        do_op(C_DIV, 32'hFFFF_FFF9, 32'd0, lat, res, ok);
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_dz_res got=%h want=FFFFFFFF", res); end
        @(negedge clk);
        do_op(C_REMU, 32'hFFFF_FFF9, 32'd0, lat, res, ok);
        checks++; if (res !== 32'hFFFF_FFF9) begin errors++; $display("FAIL remu_dz_res got=%h want=FFFFFFF9", res); end
        @(negedge clk);
        do_op(C_REM, 32'd5, 32'd0, lat, res, ok);
        checks++; if (res !== 32'd5) begin errors++; $display("FAIL rem_dz_res got=%h want=5", res); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rem_dz_handshake got=%b want=1", ok); end
        @(negedge clk);
        do_op(C_REM, 32'hFFFF_FFFD, 32'd10, lat, res, ok);
        checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL rem_small_res got=%h want=FFFFFFFD", res); end
        checks++; if (lat !== SPEC_LAT) begin errors++; $display("FAIL rem_small_lat got=%0d want=%0d", lat, SPEC_LAT); end
        @(negedge clk);
        do_op(C_DIV, 32'hFFFF_FFFD, 32'd10, lat, res, ok);
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL div_small_res got=%h want=0", res); end
        @(negedge clk);
        do_op(C_DIVU, 32'hFFFF_FFFF, 32'd1, lat, res, ok);
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_max_res got=%h want=FFFFFFFF", res); end
        @(negedge clk);
    endtask

    task automatic test_flush;
        int lat; logic [31:0] res; bit ok; bit seen; logic [31:0] prev;
        prev = result;
        start = 1'b1; alucode = C_DIVU; op1 = 32'd1000; op2 = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_run_busy got=%b want=0", busy); end
        seen = 1'b0;
        repeat (40) begin
            if (valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_run_novalid got=%b want=0", seen); end
        checks++; if (result !== prev) begin errors++; $display("FAIL flush_run_hold got=%h want=%h", result, prev); end
        do_op(C_DIVU, 32'd1000, 32'd3, lat, res, ok);
        checks++; if (res !== 32'd333) begin errors++; $display("FAIL flush_relaunch_res got=%h want=%h", res, 32'd333); end
        @(negedge clk);

        // flush in the FIX cycle beats the valid strobe
        prev = result;
        start = 1'b1; alucode = C_DIVU; op1 = 32'd77; op2 = 32'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (FULL_LAT - 1) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_fix_busy_before got=%b want=1", busy); end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL flush_fix_valid got=%b want=0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_fix_busy got=%b want=0", busy); end
        checks++; if (result !== prev) begin errors++; $display("FAIL flush_fix_hold got=%h want=%h", result, prev); end

        // flush with start in IDLE suppresses the launch
        start = 1'b1; flush = 1'b1; alucode = C_DIVU; op1 = 32'd9; op2 = 32'd2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy got=%b want=0", busy); end
        seen = 1'b0;
        repeat (40) begin
            if (valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_idle_novalid got=%b want=0", seen); end
    endtask

    task automatic test_midstart;
        int k; int lat; logic [31:0] res;
        start = 1'b1; alucode = C_DIVU; op1 = 32'd1000; op2 = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; alucode = C_DIVU; op1 = 32'd9; op2 = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 5; lat = -1; res = 32'hDEAD_BEEF;
        while (k <= 200) begin
            if (valid === 1'b1) begin
                lat = k;
                res = result;
                break;
            end
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        checks++; if (res !== 32'd142) begin errors++; $display("FAIL midstart_res got=%h want=%h", res, 32'd142); end
        checks++; if (lat !== FULL_LAT) begin errors++; $display("FAIL midstart_lat got=%0d want=%0d", lat, FULL_LAT); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midstart_no_queue got=%b want=0", busy); end
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] res; bit ok;
        do_op(C_DIVU, 32'd250, 32'd9, lat, res, ok);
        checks++; if (res !== 32'd27) begin errors++; $display("FAIL b2b_first_res got=%h want=%h", res, 32'd27); end
        do_op(C_REMU, 32'd250, 32'd9, lat, res, ok);
        checks++; if (res !== 32'd7) begin errors++; $display("FAIL b2b_second_res got=%h want=%h", res, 32'd7); end
        checks++; if (lat !== FULL_LAT) begin errors++; $display("FAIL b2b_second_lat got=%0d want=%0d", lat, FULL_LAT); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_handshake got=%b want=1", ok); end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        bit seen;
        start = 1'b1; alucode = C_DIVU; op1 = 32'd100; op2 = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        checks++; if (result === 32'h0) begin errors++; $display("FAIL areset_precond got=%h want=nonzero", result); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL areset_busy got=%b want=0", busy); end
        checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL areset_valid got=%b want=0", valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL areset_result got=%h want=0", result); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1; alucode = C_ADD; op1 = 32'd3; op2 = 32'd4;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL add_stall got=%b want=0", stall); end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy got=%b want=0", busy); end
        seen = 1'b0;
        repeat (40) begin
            if (valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL add_novalid got=%b want=0", seen); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL add_result got=%h want=0", result); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_flush();
        test_midstart();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
